accumulator_command_scheduler: RTL and testbench

ACCUMULATOR_COMMAND_SCHEDULER -- requirements
Module: accumulator_command_scheduler

---
 rtl/accumulator_command_scheduler_if.sv | 30 +++
 rtl/accumulator_command_scheduler.sv | 168 ++++++++++++++++
 tb/tb_accumulator_command_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_command_scheduler_if.sv
// Requester-side command/response bundle for the accumulator command scheduler.
// master = requesters, slave = scheduler.
`timescale 1ns/1ps
interface accumulator_command_scheduler_if #(
  parameter int REQUESTER_COUNT = 4,
  parameter int WORD_WIDTH      = 16
);
  logic [REQUESTER_COUNT-1:0]            request_valid;
  logic [REQUESTER_COUNT-1:0]            request_ready;
  logic [2*REQUESTER_COUNT-1:0]          request_opcode;
  logic [WORD_WIDTH*REQUESTER_COUNT-1:0] request_value;
  logic [REQUESTER_COUNT-1:0]            response_valid;
  logic [REQUESTER_COUNT-1:0]            response_ready;
  logic [WORD_WIDTH-1:0]                 response_value;
  logic                                  response_overflow;
  logic                                  response_carry;
  logic                                  response_error;

  modport master (
    output request_valid, request_opcode, request_value, response_ready,
    input  request_ready, response_valid, response_value,
           response_overflow, response_carry, response_error
  );

  modport slave (
    input  request_valid, request_opcode, request_value, response_ready,
    output request_ready, response_valid, response_value,
           response_overflow, response_carry, response_error
  );
endinterface

// File: rtl/accumulator_command_scheduler.sv
// Round-robin arbiter feeding one command at a time to an accumulator; accept->pulse 1 cycle,
// response 1 cycle after done (or after timeout); response held until the granted requester is ready.
`timescale 1ns/1ps
module accumulator_command_scheduler #(
  parameter int REQUESTER_COUNT = 4,
  parameter int WORD_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  accumulator_command_scheduler_if.slave req,
  output logic                  acc_increment_valid,
  output logic                  acc_load_valid,
  output logic                  acc_clear,
  output logic [WORD_WIDTH-1:0] acc_increment_value,
  output logic [WORD_WIDTH-1:0] acc_load_value,
  output logic                  acc_carry_in,
  output logic                  acc_clock_enable,
  input  logic                  acc_increment_done,
  input  logic                  acc_load_done,
  input  logic                  acc_clear_done,
  input  logic                  acc_carry_out,
  input  logic                  acc_signed_overflow,
  input  logic [WORD_WIDTH-1:0] acc_accumulated_value,
  output logic                  busy
);
  localparam int IDX_W = $clog2(REQUESTER_COUNT);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [1:0]            state;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      last_grant;
  logic [1:0]            op_q;
  logic [WORD_WIDTH-1:0] val_q;
  logic [TMR_W-1:0]      timer;
  logic [WORD_WIDTH-1:0] resp_value;
  logic                  resp_ovf;
  logic                  resp_carry;
  logic                  resp_err;
  logic                  clk_en_q;

  logic [1:0]            op_arr  [REQUESTER_COUNT];
  logic [WORD_WIDTH-1:0] val_arr [REQUESTER_COUNT];

  for (genvar gi = 0; gi < REQUESTER_COUNT; gi++) begin : g_unpack
    assign op_arr[gi]  = req.request_opcode[2*gi +: 2];
    assign val_arr[gi] = req.request_value[WORD_WIDTH*gi +: WORD_WIDTH];
  end

  // Search starts just after the last winner so every requester gets a turn.
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= REQUESTER_COUNT; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % REQUESTER_COUNT);
      if (!grant_found && req.request_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  logic done_match;
  always_comb begin
    case (op_q)
      OP_INC:  done_match = acc_increment_done;
      OP_LOAD: done_match = acc_load_done;
      OP_CLR:  done_match = acc_clear_done;
      default: done_match = 1'b0;
    endcase
  end

  assign req.request_ready = (state == S_IDLE && grant_found && !reset)
                             ? (REQUESTER_COUNT'(1) << grant_idx) : '0;
  assign req.response_valid = (state == S_RESPOND)
                              ? (REQUESTER_COUNT'(1) << grant_q) : '0;
  assign req.response_value    = resp_value;
  assign req.response_overflow = resp_ovf;
  assign req.response_carry    = resp_carry;
  assign req.response_error    = resp_err;

  assign acc_increment_valid = (state == S_ISSUE) && (op_q == OP_INC);
  assign acc_load_valid      = (state == S_ISSUE) && (op_q == OP_LOAD);
  assign acc_clear           = (state == S_ISSUE) && (op_q == OP_CLR);
  assign acc_increment_value = acc_increment_valid ? val_q : '0;
  assign acc_load_value      = acc_load_valid ? val_q : '0;
  assign acc_carry_in        = 1'b0;
  assign acc_clock_enable    = clk_en_q;
  assign busy                = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      last_grant <= IDX_W'(REQUESTER_COUNT - 1);
      op_q       <= '0;
      val_q      <= '0;
      timer      <= '0;
      resp_value <= '0;
      resp_ovf   <= 1'b0;
      resp_carry <= 1'b0;
      resp_err   <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      clk_en_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            grant_q    <= grant_idx;
            last_grant <= grant_idx;
            op_q       <= op_arr[grant_idx];
            val_q      <= val_arr[grant_idx];
            if (op_arr[grant_idx] == OP_RSVD) begin
              resp_value <= '0;
              resp_ovf   <= 1'b0;
              resp_carry <= 1'b0;
              resp_err   <= 1'b1;
              state      <= S_RESPOND;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done landing on the final count wins over the timeout.
          if (done_match) begin
            resp_value <= acc_accumulated_value;
            resp_ovf   <= acc_signed_overflow;
            resp_carry <= acc_carry_out;
            resp_err   <= 1'b0;
            state      <= S_RESPOND;
          end else if (timer == TMR_LAST) begin
            resp_value <= '0;
            resp_ovf   <= 1'b0;
            resp_carry <= 1'b0;
            resp_err   <= 1'b1;
            state      <= S_RESPOND;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_RESPOND: begin
          if (req.response_ready[grant_q]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accumulator_command_scheduler.sv
// Self-checking bench: accumulator model with no extra pipe stages, table vectors plus
// directed arbitration, timeout and reset sequences, scoreboarded responses.
`timescale 1ns/1ps
module tb_accumulator_command_scheduler;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  accumulator_command_scheduler_if #(.REQUESTER_COUNT(N), .WORD_WIDTH(W)) ifc ();

  logic         acc_increment_valid, acc_load_valid, acc_clear, acc_carry_in, acc_clock_enable, busy;
  logic [W-1:0] acc_increment_value, acc_load_value, acc_accumulated_value;
  logic         acc_increment_done, acc_load_done, acc_clear_done, acc_carry_out, acc_signed_overflow;

  accumulator_command_scheduler #(.REQUESTER_COUNT(N), .WORD_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .req(ifc.slave),
    .acc_increment_valid(acc_increment_valid), .acc_load_valid(acc_load_valid),
    .acc_clear(acc_clear), .acc_increment_value(acc_increment_value),
    .acc_load_value(acc_load_value), .acc_carry_in(acc_carry_in),
    .acc_clock_enable(acc_clock_enable), .acc_increment_done(acc_increment_done),
    .acc_load_done(acc_load_done), .acc_clear_done(acc_clear_done),
    .acc_carry_out(acc_carry_out), .acc_signed_overflow(acc_signed_overflow),
    .acc_accumulated_value(acc_accumulated_value), .busy(busy)
  );

  // Accumulator model; mute suppresses its done pulses, x_* inject hand-made ones.
  logic         mute;
  logic [W-1:0] m_acc;
  logic         m_inc_done, m_load_done, m_clr_done, m_carry, m_ovf;
  logic [W:0]   m_sum;
  logic         x_inc_done, x_load_done, x_clr_done, x_ovr, x_ovf, x_carry;
  logic [W-1:0] x_val;

  assign m_sum = {1'b0, m_acc} + {1'b0, acc_increment_value};

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_acc <= '0; m_carry <= 1'b0; m_ovf <= 1'b0;
      m_inc_done <= 1'b0; m_load_done <= 1'b0; m_clr_done <= 1'b0;
    end else begin
      m_inc_done <= 1'b0; m_load_done <= 1'b0; m_clr_done <= 1'b0;
      if (!mute && acc_clock_enable) begin
        if (acc_increment_valid) begin
          m_acc      <= m_sum[W-1:0];
          m_carry    <= m_sum[W];
          m_ovf      <= (m_acc[W-1] == acc_increment_value[W-1]) && (m_sum[W-1] != m_acc[W-1]);
          m_inc_done <= 1'b1;
        end else if (acc_load_valid) begin
          m_acc <= acc_load_value; m_carry <= 1'b0; m_ovf <= 1'b0; m_load_done <= 1'b1;
        end else if (acc_clear) begin
          m_acc <= '0; m_carry <= 1'b0; m_ovf <= 1'b0; m_clr_done <= 1'b1;
        end
      end
    end
  end

  assign acc_increment_done    = m_inc_done | x_inc_done;
  assign acc_load_done         = m_load_done | x_load_done;
  assign acc_clear_done        = m_clr_done | x_clr_done;
  assign acc_accumulated_value = x_ovr ? x_val : m_acc;
  assign acc_signed_overflow   = x_ovr ? x_ovf : m_ovf;
  assign acc_carry_out         = x_ovr ? x_carry : m_carry;

  typedef struct {
    int         req;
    logic [W-1:0] val;
    logic       ovf;
    logic       carry;
    logic       err;
  } resp_t;

  typedef struct {
    int         req;
    logic [1:0] op;
    logic [W-1:0] v;
    logic [W-1:0] e_val;
    logic       e_ovf;
    logic       e_carry;
    logic       e_err;
    int         lat;
  } vec_t;

  resp_t  exp_q[$];
  int     order_q[$];
  vec_t   vecs[10];
  int     total = 0;
  int     bad   = 0;
  logic [W-1:0] ref_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_resp(input int r);
    resp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: response from req %0d, none expected", r);
    end else begin
      e = exp_q.pop_front();
      chk("resp_onehot", 32'(ifc.response_valid), 32'(1) << r);
      chk("resp_req", r, e.req);
      chk("resp_val", ifc.response_value, e.val);
      chk("resp_ovf", ifc.response_overflow, e.ovf);
      chk("resp_carry", ifc.response_carry, e.carry);
      chk("resp_err", ifc.response_error, e.err);
    end
  endtask

  task automatic push_exp(input int r, input logic [W-1:0] v, input logic o, input logic c, input logic e);
    resp_t x;
    x.req = r; x.val = v; x.ovf = o; x.carry = c; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic issue(input int r, input logic [1:0] op, input logic [W-1:0] v);
    bit got;
    got = 1'b0;
    @(negedge clock);
    ifc.request_valid[r]         = 1'b1;
    ifc.request_opcode[2*r +: 2] = op;
    ifc.request_value[W*r +: W]  = v;
    #1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (ifc.request_ready[r]) got = 1'b1;
      else @(negedge clock);
    end
    chk("accept", got, 1);
  endtask

  task automatic collect(input int r);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      if (ifc.response_valid[r] && ifc.response_ready[r]) begin
        cmp_resp(r);
        done = 1'b1;
      end else @(negedge clock);
    end
    chk("handshake", done, 1);
  endtask

  task automatic send(input vec_t t);
    int cnt, pulses;
    bit got;
    logic [2:0] p1, exp_p1;
    issue(t.req, t.op, t.v);
    push_exp(t.req, t.e_val, t.e_ovf, t.e_carry, t.e_err);
    cnt = 0; pulses = 0; got = 1'b0; p1 = '0;
    while (!got && cnt < 100) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) begin
        ifc.request_valid[t.req] = 1'b0;
        p1 = {acc_increment_valid, acc_load_valid, acc_clear};
      end
      pulses += int'(acc_increment_valid) + int'(acc_load_valid) + int'(acc_clear);
      if (ifc.response_valid[t.req]) got = 1'b1;
    end
    case (t.op)
      2'b00:   exp_p1 = 3'b100;
      2'b01:   exp_p1 = 3'b010;
      2'b10:   exp_p1 = 3'b001;
      default: exp_p1 = 3'b000;
    endcase
    chk("resp_seen", got, 1);
    chk("latency", cnt, t.lat);
    chk("pulse_kind", p1, exp_p1);
    chk("pulse_count", pulses, (t.op == 2'b11) ? 0 : 1);
    collect(t.req);
  endtask

  // Increment-only traffic from several requesters; responses scoreboarded in accept order.
  task automatic run_rr(input bit continuous, input int n_acc);
    int accepts, resps, cyc;
    logic [N-1:0] drop;
    accepts = 0; resps = 0; cyc = 0; drop = '0;
    while (resps < n_acc && cyc < 300) begin
      #1;
      chk("ready_onehot0", $onehot0(ifc.request_ready), 1);
      for (int i = 0; i < N; i++) begin
        if (ifc.request_ready[i] && ifc.request_valid[i]) begin
          order_q.push_back(i);
          accepts++;
          ref_acc = ref_acc + ifc.request_value[W*i +: W];
          push_exp(i, ref_acc, 1'b0, 1'b0, 1'b0);
          if (!continuous) drop[i] = 1'b1;
          else if (accepts >= n_acc) drop = ifc.request_valid;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ifc.response_valid[i] && ifc.response_ready[i]) begin
          cmp_resp(i);
          resps++;
        end
      end
      @(negedge clock);
      ifc.request_valid = ifc.request_valid & ~drop;
      drop = '0;
      cyc++;
    end
    chk("rr_responses", resps, n_acc);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    order_q.delete();
    ref_acc = '0;
  endtask

  initial begin
    int cnt;
    bit got;
    ifc.request_valid  = '0;
    ifc.request_opcode = '0;
    ifc.request_value  = '0;
    ifc.response_ready = '1;
    mute = 1'b0;
    x_inc_done = 1'b0; x_load_done = 1'b0; x_clr_done = 1'b0;
    x_ovr = 1'b0; x_ovf = 1'b0; x_carry = 1'b0; x_val = '0;
    ref_acc = '0;

    vecs[0] = '{0, 2'b00 + 2'b01, 16'h7FFF, 16'h7FFF, 0, 0, 0, 3};
    vecs[1] = '{1, 2'b00, 16'h0001, 16'h8000, 1, 0, 0, 3};
    vecs[2] = '{2, 2'b00, 16'h8000, 16'h0000, 1, 1, 0, 3};
    vecs[3] = '{3, 2'b01, 16'hFFFF, 16'hFFFF, 0, 0, 0, 3};
    vecs[4] = '{0, 2'b00, 16'h0001, 16'h0000, 0, 1, 0, 3};
    vecs[5] = '{1, 2'b11, 16'h1234, 16'h0000, 0, 0, 1, 1};
    vecs[6] = '{2, 2'b00, 16'h0005, 16'h0005, 0, 0, 0, 3};
    vecs[7] = '{3, 2'b10, 16'hBEEF, 16'h0000, 0, 0, 0, 3};
    vecs[8] = '{0, 2'b00, 16'h7FFF, 16'h7FFF, 0, 0, 0, 3};
    vecs[9] = '{1, 2'b00, 16'h7FFF, 16'hFFFE, 1, 0, 0, 3};

    // Reset state, with requests pending to prove ready stays low.
    ifc.request_valid = 4'b0101;
    repeat (2) @(negedge clock);
    chk("rst_request_ready", ifc.request_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_response_valid", ifc.response_valid, 0);
    chk("rst_acc_cmds", {acc_increment_valid, acc_load_valid, acc_clear}, 0);
    chk("rst_acc_values", {acc_increment_value, acc_load_value}, 0);
    chk("rst_clock_enable", acc_clock_enable, 0);
    chk("rst_carry_in", acc_carry_in, 0);
    chk("rst_response_regs", {ifc.response_value, ifc.response_overflow,
                              ifc.response_carry, ifc.response_error}, 0);
    ifc.request_valid = '0;
    reset = 1'b0;
    @(negedge clock);
    chk("clock_enable_on", acc_clock_enable, 1);

    // Requesters 0 and 2 increment 5 and 7 from a cleared accumulator.
    ifc.request_opcode = '0;
    ifc.request_value[W*0 +: W] = 16'd5;
    ifc.request_value[W*2 +: W] = 16'd7;
    ifc.request_valid = 4'b0101;
    run_rr(1'b0, 2);
    chk("pair_count", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("pair_first", order_q[0], 0);
      chk("pair_second", order_q[1], 2);
    end

    // All four continuously valid from reset.
    do_reset();
    ifc.request_opcode = '0;
    for (int i = 0; i < N; i++) ifc.request_value[W*i +: W] = W'(i + 1);
    ifc.request_valid = '1;
    run_rr(1'b1, 5);
    chk("rr_count", order_q.size(), 5);
    if (order_q.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", order_q[i], i % N);
    end

    for (int i = 0; i < 10; i++) send(vecs[i]);

    // Matching done on the final wait cycle resolves as done.
    mute = 1'b1;
    issue(0, 2'b00, 16'h0001);
    push_exp(0, 16'hABCD, 1'b1, 1'b1, 1'b0);
    cnt = 0; got = 1'b0;
    while (!got && cnt < TO + 10) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) ifc.request_valid[0] = 1'b0;
      x_inc_done = (cnt == TO + 1);
      x_ovr      = (cnt == TO + 1);
      x_val = 16'hABCD; x_ovf = 1'b1; x_carry = 1'b1;
      #1;
      if (ifc.response_valid[0]) got = 1'b1;
    end
    chk("edge_done_seen", got, 1);
    chk("edge_done_latency", cnt, TO + 2);
    collect(0);

    // Timeout with non-matching dones ignored; response held until its own ready.
    ifc.response_ready[2] = 1'b0;
    issue(2, 2'b00, 16'h0003);
    push_exp(2, 16'h0000, 1'b0, 1'b0, 1'b1);
    cnt = 0; got = 1'b0;
    while (!got && cnt < TO + 10) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) ifc.request_valid[2] = 1'b0;
      x_load_done = (cnt == 4);
      x_clr_done  = (cnt == 5);
      #1;
      if (ifc.response_valid[2]) got = 1'b1;
    end
    chk("timeout_seen", got, 1);
    chk("timeout_latency", cnt, TO + 2);
    repeat (4) begin
      @(negedge clock);
      chk("timeout_hold_valid", ifc.response_valid, 4'b0100);
      chk("timeout_hold_err", ifc.response_error, 1);
      chk("timeout_hold_busy", busy, 1);
    end
    ifc.response_ready[2] = 1'b1;
    collect(2);

    // Reset during WAIT, then a stray done.
    issue(1, 2'b00, 16'h0009);
    repeat (3) begin
      @(negedge clock);
      ifc.request_valid[1] = 1'b0;
    end
    chk("wait_busy", busy, 1);
    reset = 1'b1;
    ifc.request_valid[3] = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_response_valid", ifc.response_valid, 0);
    chk("midrst_request_ready", ifc.request_ready, 0);
    chk("midrst_clock_enable", acc_clock_enable, 0);
    @(negedge clock);
    reset = 1'b0;
    ifc.request_valid[3] = 1'b0;
    exp_q.delete();
    @(negedge clock);
    x_inc_done = 1'b1; x_ovr = 1'b1; x_val = 16'h1111;
    @(negedge clock);
    x_inc_done = 1'b0; x_ovr = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("late_done_no_resp", ifc.response_valid, 0);
      chk("late_done_idle", busy, 0);
    end
    chk("postrst_clock_enable", acc_clock_enable, 1);
    mute = 1'b0;
    send('{2, 2'b00, 16'h0004, 16'h0004, 0, 0, 0, 3});
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
